// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - state encoding, default phase lengths and pixel width for the pixel row controller
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_DRAIN   = 3'd5
  } ctrl_state_t;

  localparam int DEF_C_ERASE   = 5;
  localparam int DEF_C_EXPOSE  = 255;
  localparam int DEF_C_CONVERT = 255;
  localparam int DEF_C_READ    = 5;
  localparam int PIXEL_BITS    = 8;

  // Phase entered after the gap that follows s.
  function automatic ctrl_state_t phase_after(input ctrl_state_t s);
    case (s)
      ST_ERASE:   return ST_EXPOSE;
      ST_EXPOSE:  return ST_CONVERT;
      ST_CONVERT: return ST_READ;
      ST_READ:    return ST_DRAIN;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pixel_row_controller_if.sv
// rtl/pixel_row_controller_if.sv - pixel byte stream toward the downstream readout logic
interface pixel_row_controller_if;
  import pixel_ctrl_pkg::*;

  logic                  pix_valid;
  logic                  pix_ready;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  pix_last;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);

endinterface

// File: rtl/pixel_row_drain.sv
// rtl/pixel_row_drain.sv - row capture buffer and one-pixel-per-handshake drain of the captured row
module pixel_row_drain
  import pixel_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic                      start,
  input  logic [W*PIXEL_BITS-1:0]   row_data,
  pixel_row_controller_if.master    pix,
  output logic                      done
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [PIXEL_BITS-1:0] buffer [W];
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;

  assign idx_nxt = idx + 1'b1;
  assign done    = pix.pix_valid && pix.pix_ready && pix.pix_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) buffer[i] <= '0;
      idx           <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.pix_last  <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < W; i++) buffer[i] <= row_data[i*PIXEL_BITS +: PIXEL_BITS];
      end
      if (start) begin
        idx           <= '0;
        pix.pix_valid <= 1'b1;
        pix.pix_data  <= buffer[0];
        pix.pix_last  <= (W == 1);
      end else if (pix.pix_valid && pix.pix_ready) begin
        if (pix.pix_last) begin
          pix.pix_valid <= 1'b0;
          pix.pix_last  <= 1'b0;
        end else begin
          // pix_data only moves on a handshake, so it is stable under backpressure
          idx          <= idx_nxt;
          pix.pix_data <= buffer[idx_nxt];
          pix.pix_last <= (idx_nxt == IW'(W - 1));
        end
      end
    end
  end

endmodule

// File: rtl/pixel_row_controller.sv
// rtl/pixel_row_controller.sv - ERASE/EXPOSE/CONVERT/READ sequencer with ADC ramp and row readout stream
// Optional frame counter output enabled by PIXEL_ROW_CTRL_FRAME_COUNT_EN.
module pixel_row_controller
  import pixel_ctrl_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH = 4,
  parameter int C_ERASE           = DEF_C_ERASE,
  parameter int C_EXPOSE          = DEF_C_EXPOSE,
  parameter int C_CONVERT         = DEF_C_CONVERT,
  parameter int C_READ            = DEF_C_READ
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
  output logic                                    erase,
  output logic                                    expose,
  output logic                                    convert,
  output logic                                    read,
  output logic [7:0]                              counter,
  output logic                                    busy,
`ifdef PIXEL_ROW_CTRL_FRAME_COUNT_EN
  output logic [15:0]                             frame_count,
`endif
  pixel_row_controller_if.master                  pix
);

  localparam int C_MAX_A = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int C_MAX_B = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
  localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int CW      = $clog2(C_MAX + 1);

  ctrl_state_t state;
  ctrl_state_t next_phase;
  logic        gap;
  logic [CW-1:0] cnt;
  logic        last_cycle;
  logic        capture;
  logic        start;
  logic        done;

  always_comb begin
    last_cycle = 1'b0;
    case (state)
      ST_ERASE:   last_cycle = (cnt == CW'(C_ERASE - 1));
      ST_EXPOSE:  last_cycle = (cnt == CW'(C_EXPOSE - 1));
      ST_CONVERT: last_cycle = (cnt == CW'(C_CONVERT - 1));
      ST_READ:    last_cycle = (cnt == CW'(C_READ - 1));
      default:    last_cycle = 1'b0;
    endcase
  end

  // Row is sampled at the edge closing the final READ cycle; drain starts at the end of the gap.
  assign capture = (state == ST_READ) && last_cycle;
  assign start   = (state == ST_IDLE) && gap && (next_phase == ST_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      next_phase <= ST_IDLE;
      gap        <= 1'b0;
      cnt        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= 1'b0;
      counter    <= '0;
      busy       <= 1'b0;
    end else begin
      erase   <= 1'b0;
      expose  <= 1'b0;
      convert <= 1'b0;
      read    <= 1'b0;
      counter <= '0;
      busy    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (gap) begin
            gap     <= 1'b0;
            state   <= next_phase;
            expose  <= (next_phase == ST_EXPOSE);
            convert <= (next_phase == ST_CONVERT);
            read    <= (next_phase == ST_READ);
            busy    <= 1'b1;
          end else if (enable) begin
            state <= ST_ERASE;
            erase <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_ERASE, ST_EXPOSE, ST_CONVERT, ST_READ: begin
          if (last_cycle) begin
            state      <= ST_IDLE;
            gap        <= 1'b1;
            next_phase <= phase_after(state);
            cnt        <= '0;
          end else begin
            cnt     <= cnt + 1'b1;
            busy    <= 1'b1;
            erase   <= (state == ST_ERASE);
            expose  <= (state == ST_EXPOSE);
            convert <= (state == ST_CONVERT);
            read    <= (state == ST_READ);
            if (state == ST_CONVERT) counter <= 8'(cnt + 1'b1);
          end
        end
        ST_DRAIN: begin
          // No gap flag here: a new frame only starts if enable is still high.
          if (done) state <= ST_IDLE;
          else      busy  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pixel_row_drain #(.W(PIXEL_ARRAY_WIDTH)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .start    (start),
    .row_data (row_data),
    .pix      (pix),
    .done     (done)
  );

`ifdef PIXEL_ROW_CTRL_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    frame_count <= '0;
    else if (done) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: doc/pixel_row_controller.md
# pixel_row_controller

Sequencing and readout controller for one pixel row. Drives ERASE, EXPOSE, CONVERT and READ into `PIXEL_ROW`, generates the 8-bit digital ramp on COUNTER during conversion, and captures the row's DATA_OUT bus on the final READ cycle. The captured pixels leave as a byte stream, one pixel per handshake, toward the downstream readout logic.

## Interface
- PIXEL_ARRAY_WIDTH, 4: pixels per row; must be ≥1.
- C_ERASE, 5: ERASE phase length in cycles; must be ≥1.
- C_EXPOSE, 255: EXPOSE phase length in cycles; must be ≥1.
- C_CONVERT, 255: CONVERT phase length in cycles; range 1–256.
- C_READ, 5: READ phase length in cycles; must be ≥1.
- clk, in, 1: single clock; all logic on posedge.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: run frames continuously while high.
- row_data, in, PIXEL_ARRAY_WIDTH×8: packed pixel bus from `PIXEL_ROW` DATA_OUT; pixel i is bits [8i+7:8i].
- erase, out, 1: high during the ERASE phase.
- expose, out, 1: high during the EXPOSE phase.
- convert, out, 1: high during the CONVERT phase.
- read, out, 1: high during the READ phase.
- counter, out, 8: ADC ramp value driven to `PIXEL_ROW` COUNTER.
- pix_valid, out, 1: stream valid.
- pix_ready, in, 1: stream ready from the consumer.
- pix_data, out, 8: current pixel.
- pix_last, out, 1: high with the final pixel of a row.
- busy, out, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ, DRAIN. A shared `ctrl_state_t` enum encodes them.
- Frame order: ERASE → EXPOSE → CONVERT → READ → DRAIN. Exactly one GAP cycle (IDLE-encoded, all control outputs low) separates consecutive phases, and DRAIN→ERASE also has one gap.
- A phase counter is cleared on entry to each phase and increments every cycle. The phase exits when the counter reaches C_x−1, so each phase lasts exactly C_x cycles.
- Starting a frame:
  - From IDLE, enable=1 at a posedge starts ERASE on the next cycle.
  - With enable=0, the FSM stays in IDLE.
- Stopping: if enable drops mid-frame, the current frame finishes, including DRAIN. The FSM then parks in IDLE and does not take the DRAIN→ERASE gap.
- counter behaviour:
  - In CONVERT it equals the phase count: 0 on the first CONVERT cycle, C_CONVERT−1 on the last.
  - In every other state it is 0.
  - It never wraps within a phase.
- Capture: on the last READ cycle, row_data is registered into a PIXEL_ARRAY_WIDTH×8 buffer. Values sampled earlier in READ are ignored.
- DRAIN:
  - A pixel index runs from 0 to W−1. pix_valid=1 and pix_data=buffer[index].
  - The index advances only on a cycle where pix_valid && pix_ready.
  - pix_last=1 when index=W−1.
  - The handshake on the last pixel ends DRAIN.
  - The consumer may hold pix_ready low indefinitely. The FSM stalls in DRAIN and pix_data stays stable.
- Only one control output (erase, expose, convert, read) is ever high at a time.

## Timing
- All outputs are registered.
- Reset (reset=0), asynchronously and independent of clk:
  - State IDLE.
  - erase=expose=convert=read=0.
  - counter=0, pix_valid=0, pix_data=0, pix_last=0, busy=0.
  - Capture buffer cleared.
- Reset mid-frame aborts immediately. Partial data is discarded and no pix_valid is issued afterward.
- Latency from enable sampled high to erase=1 is 1 cycle.
- Frame length, with an always-ready consumer: C_ERASE+C_EXPOSE+C_CONVERT+C_READ+W+5 cycles. The 5 counts four inter-phase gaps plus the DRAIN→ERASE gap.
- pix_valid rises one gap cycle after read falls.
- Once asserted, pix_valid stays high until the handshake completes.

## Configuration
- Macro: `PIXEL_ROW_CTRL_FRAME_COUNT_EN`.
- When defined:
  - Adds output `frame_count` (16 bits), reset to 0.
  - It increments by 1 on the pix_last handshake and wraps from 0xFFFF to 0.
  - An aborted frame does not increment it.
- When undefined: the port and register do not exist. Behaviour is otherwise identical.

## Structure
- Package `pixel_ctrl_pkg` holds:
  - the `ctrl_state_t` enum;
  - default phase-length constants (C_ERASE, C_EXPOSE, C_CONVERT, C_READ);
  - the pixel width constant (8).
- One sub-module: `pixel_row_drain`. It contains the capture buffer, the pixel index and the valid/ready/last logic. It takes `capture` and `start` strobes from the FSM and returns `done`.

## Test plan
- Reset then idle:
  - reset=0 mid-CONVERT at counter=100 → all outputs 0 asynchronously.
  - Release with enable=0 → FSM stays in IDLE and busy=0 for 50 cycles.
- Nominal frame, W=4, enable=1, pix_ready=1:
  - erase high for 5 cycles, expose 255, convert 255, read 5, each with a single gap between.
  - counter runs 0…254 during CONVERT and reads 0 elsewhere.
- Capture:
  - row_data = 0x44332211 on the last READ cycle, different values earlier → stream 0x11, 0x22, 0x33, 0x44.
  - pix_last is high only on 0x44.
- Backpressure: pix_ready low for 10 cycles after pix_valid rises → pix_data holds 0x11, the FSM stays in DRAIN, and no ERASE starts.
- Stop: enable dropped during EXPOSE → the frame completes all 4 pixels, then busy=0 and erase is never reasserted.
- With `PIXEL_ROW_CTRL_FRAME_COUNT_EN` defined: 3 full frames → frame_count=3. A 4th frame aborted by reset → frame_count=0.
